// File: rtl/sdram_rd_byte_streamer.sv
// Drains 16-bit words from the SDRAM read FIFO and serialises each word into two bytes on a
// valid/ready stream. A transfer of XFER_WORDS words starts on a start pulse while idle.
module sdram_rd_byte_streamer #(
  parameter int unsigned XFER_WORDS = 1024,
  parameter int unsigned THRESH     = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        rd_valid,
  input  logic [9:0]  rd_fifo_num,
  output logic        rd_fifo_rd_req,
  input  logic [15:0] rd_fifo_rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [23:0] XferWords = 24'(XFER_WORDS);
  localparam logic [23:0] Thresh    = 24'(THRESH);

  typedef enum logic [2:0] {
    StIdle, StFill, StPop, StCapt, StB0, StB1, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] remaining_q, remaining_d;
  logic [15:0] word_q, word_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        rd_req_q, rd_req_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [23:0] fill_min;
  logic [23:0] num_ext;

  // Byte-lane selection for the first and second byte of a word.
  function automatic logic [7:0] first_byte(input logic [15:0] w);
    return MSB_FIRST ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
    return MSB_FIRST ? w[7:0] : w[15:8];
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      word_q      <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      rd_req_q    <= rd_req_d;
      rd_valid_q  <= rd_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and next-output logic; pop request is raised on entry to StPop so the
  // registered rd_fifo_rd_req is high for exactly the StPop cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    rd_req_d    = 1'b0;
    rd_valid_d  = rd_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    // Short tail transfers only wait for what is still owed, avoiding a deadlock.
    fill_min = (Thresh < remaining_q) ? Thresh : remaining_q;
    num_ext  = {14'd0, rd_fifo_num};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d = XferWords;
          busy_d      = 1'b1;
          rd_valid_d  = 1'b1;
          state_d     = StFill;
        end
      end
      StFill: begin
        if ((num_ext >= fill_min) && (rd_fifo_num != 10'd0)) begin
          rd_req_d = 1'b1;
          state_d  = StPop;
        end
      end
      StPop: begin
        remaining_d = remaining_q - 24'd1;
        state_d     = StCapt;
      end
      StCapt: begin
        word_d     = rd_fifo_rd_data;
        tx_data_d  = first_byte(rd_fifo_rd_data);
        tx_valid_d = 1'b1;
        state_d    = StB0;
      end
      StB0: begin
        if (tx_ready) begin
          tx_data_d = second_byte(word_q);
          state_d   = StB1;
        end
      end
      StB1: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (remaining_q == 24'd0) begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            rd_valid_d = 1'b0;
            state_d    = StDone;
          end else if (rd_fifo_num != 10'd0) begin
            // Burst continues without re-checking the threshold.
            rd_req_d = 1'b1;
            state_d  = StPop;
          end else begin
            state_d = StFill;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign rd_valid       = rd_valid_q;
  assign rd_fifo_rd_req = rd_req_q;
  assign tx_data        = tx_data_q;
  assign tx_valid       = tx_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_sdram_rd_byte_streamer.sv
// Bench for sdram_rd_byte_streamer: three instances with different parameter sets share one
// FIFO model; the selected instance's byte stream is checked against a queue of expected bytes.
module tb_sdram_rd_byte_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_ready = 1'b0;
  logic [9:0]  fifo_num;
  logic [15:0] fifo_rd_data = '0;

  logic        start_a    [3];
  logic        rd_valid_a [3];
  logic        req_a      [3];
  logic [7:0]  tx_data_a  [3];
  logic        tx_valid_a [3];
  logic        busy_a     [3];
  logic        done_a     [3];

  int sel = 0;
  logic       act_req, act_tx_valid, act_busy, act_done, act_rd_valid;
  logic [7:0] act_tx_data;

  // FIFO model
  logic [15:0] mem [256];
  int wr_ptr = 0;
  int rd_ptr = 0;

  // Scoreboard
  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;  // 0 low, 1 high, 2 random

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdram_rd_byte_streamer #(
      .XFER_WORDS(g == 0 ? 4 : (g == 1 ? 3 : 12)),
      .THRESH    (8),
      .MSB_FIRST (g != 1)
    ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start_a[g]),
      .rd_valid       (rd_valid_a[g]),
      .rd_fifo_num    (fifo_num),
      .rd_fifo_rd_req (req_a[g]),
      .rd_fifo_rd_data(fifo_rd_data),
      .tx_data        (tx_data_a[g]),
      .tx_valid       (tx_valid_a[g]),
      .tx_ready       (tx_ready),
      .busy           (busy_a[g]),
      .done           (done_a[g])
    );
  end

  always_comb begin
    act_req      = req_a[sel];
    act_tx_valid = tx_valid_a[sel];
    act_tx_data  = tx_data_a[sel];
    act_busy     = busy_a[sel];
    act_done     = done_a[sel];
    act_rd_valid = rd_valid_a[sel];
    fifo_num     = 10'(wr_ptr - rd_ptr);
  end

  // FIFO pop with one-cycle read latency.
  always @(posedge clk) begin
    if (act_req && (wr_ptr != rd_ptr)) begin
      fifo_rd_data <= mem[rd_ptr % 256];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Sink ready driver, updated just after each active edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = ($urandom_range(0, 9) >= 3);
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle; a byte counts as accepted when valid & ready here.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  always @(negedge clk) begin
    if (act_tx_valid && tx_ready && !rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %0h expected none", act_tx_data);
      end else begin
        chk("tx_byte", {24'd0, act_tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
    if (prev_stall && !rst) begin
      chk("stall_valid", {31'd0, act_tx_valid}, 32'd1);
      chk("stall_data", {24'd0, act_tx_data}, {24'd0, prev_data});
    end
    prev_stall = act_tx_valid && !tx_ready && !rst;
    prev_data  = act_tx_data;
    if (act_req) begin
      pop_cnt++;
      chk("no_underflow", {31'd0, (fifo_num != 10'd0)}, 32'd1);
    end
    if (act_done) done_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr++;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic exp_word(input logic [15:0] w, input bit msb);
    if (msb) begin
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end else begin
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask

  task automatic pulse_start(input int i);
    start_a[i] = 1'b1;
    step();
    start_a[i] = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", {31'd0, (done_cnt != d0)}, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_valid"}, {31'd0, act_rd_valid}, 32'd0);
    chk({tag, "_rd_req"},   {31'd0, act_req}, 32'd0);
    chk({tag, "_tx_data"},  {24'd0, act_tx_data}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, act_tx_valid}, 32'd0);
    chk({tag, "_busy"},     {31'd0, act_busy}, 32'd0);
    chk({tag, "_done"},     {31'd0, act_done}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] t2_words [4] = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
  logic [15:0] t6_words [3] = '{16'hA1B2, 16'hC3D4, 16'hE5F6};

  initial begin
    int p0, d0, n;
    for (int i = 0; i < 3; i++) start_a[i] = 1'b0;

    // Power-up reset
    rst = 1'b1;
    repeat (3) step();
    chk_idle_outputs("por");
    rst = 1'b0;
    step();

    // T1: reset while stalled in B0
    sel = 0;
    ready_mode = 0;
    for (int i = 0; i < 4; i++) push(t2_words[i]);
    pulse_start(0);
    n = 0;
    while (!act_tx_valid && n < 50) begin
      step();
      n++;
    end
    chk("t1_reached_b0", {31'd0, act_tx_valid}, 32'd1);
    rst = 1'b1;
    step();
    chk_idle_outputs("t1_rst");
    repeat (2) step();
    rst = 1'b0;
    p0 = pop_cnt;
    repeat (20) step();
    chk("t1_no_pop_after_rst", pop_cnt - p0, 0);
    chk("t1_busy_after_rst", {31'd0, act_busy}, 32'd0);
    exp_q.delete();
    flush();

    // T2: basic transfer, sink always ready
    ready_mode = 1;
    for (int i = 0; i < 4; i++) begin
      push(t2_words[i]);
      exp_word(t2_words[i], 1'b1);
    end
    p0 = pop_cnt;
    d0 = done_cnt;
    pulse_start(0);
    wait_done(d0, 200);
    repeat (5) step();
    chk("t2_pops", pop_cnt - p0, 4);
    chk("t2_done_pulses", done_cnt - d0, 1);
    chk("t2_bytes_left", exp_q.size(), 0);
    chk("t2_busy_end", {31'd0, act_busy}, 32'd0);

    // T3: same data under random backpressure
    ready_mode = 2;
    for (int i = 0; i < 4; i++) begin
      push(t2_words[i]);
      exp_word(t2_words[i], 1'b1);
    end
    p0 = pop_cnt;
    d0 = done_cnt;
    pulse_start(0);
    wait_done(d0, 500);
    repeat (5) step();
    chk("t3_pops", pop_cnt - p0, 4);
    chk("t3_bytes_left", exp_q.size(), 0);
    ready_mode = 1;

    // T4: threshold gating with 12-word transfer, THRESH=8
    sel = 2;
    flush();
    for (int i = 0; i < 12; i++) exp_word(16'h4000 + 16'(i), 1'b1);
    for (int i = 0; i < 7; i++) push(16'h4000 + 16'(i));
    p0 = pop_cnt;
    d0 = done_cnt;
    pulse_start(2);
    repeat (50) step();
    chk("t4_no_pop_at_7", pop_cnt - p0, 0);
    chk("t4_busy", {31'd0, act_busy}, 32'd1);
    push(16'h4007);
    @(negedge clk);
    chk("t4_req_same_cycle", {31'd0, act_req}, 32'd0);
    @(negedge clk);
    chk("t4_req_next_cycle", {31'd0, act_req}, 32'd1);

    // T5: FIFO runs dry mid-transfer, then parks until min(THRESH, remaining) is met
    repeat (60) step();
    chk("t5_pops_before_dry", pop_cnt - p0, 8);
    chk("t5_still_busy", {31'd0, act_busy}, 32'd1);
    chk("t5_bytes_pending", exp_q.size(), 8);
    for (int i = 8; i < 11; i++) push(16'h4000 + 16'(i));
    repeat (30) step();
    chk("t5_parked_at_3", pop_cnt - p0, 8);
    push(16'h400B);
    wait_done(d0, 200);
    repeat (3) step();
    chk("t5_total_pops", pop_cnt - p0, 12);
    chk("t5_bytes_left", exp_q.size(), 0);

    // T6: short transfer, LSB first, start pulses while busy ignored
    sel = 1;
    flush();
    for (int i = 0; i < 3; i++) begin
      push(t6_words[i]);
      exp_word(t6_words[i], 1'b0);
    end
    p0 = pop_cnt;
    d0 = done_cnt;
    pulse_start(1);
    repeat (3) step();
    pulse_start(1);
    repeat (4) step();
    pulse_start(1);
    wait_done(d0, 200);
    repeat (10) step();
    chk("t6_pops", pop_cnt - p0, 3);
    chk("t6_done_pulses", done_cnt - d0, 1);
    chk("t6_busy_end", {31'd0, act_busy}, 32'd0);
    chk("t6_bytes_left", exp_q.size(), 0);

    // start coincident with rst: reset wins
    push(16'h5555);
    rst = 1'b1;
    start_a[1] = 1'b1;
    step();
    rst = 1'b0;
    start_a[1] = 1'b0;
    repeat (3) step();
    chk("rst_beats_start", {31'd0, act_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
